// File: rtl/encoder_8to3.sv
// encoder_8to3: registered 8-to-3 priority encoder with enable.
// The highest-numbered set bit of I wins; V flags any request and M flags
// two or more requests. All outputs update one cycle after sampling E/I.
module encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] I,
    output logic [2:0] Y,
    output logic       V,
    output logic       M
);

    localparam int unsigned IN_W  = 8;
    localparam int unsigned IDX_W = 3;

    logic [IDX_W-1:0] idx_c;
    logic             any_c;
    logic             multi_c;

    logic [IDX_W-1:0] y_d, y_q;
    logic             v_d, v_q;
    logic             m_d, m_q;

    // Priority index: later (higher) set bits overwrite earlier ones.
    always_comb begin
        idx_c = '0;
        for (int n = 0; n < int'(IN_W); n++) begin
            if (I[n]) begin
                idx_c = IDX_W'(n);
            end
        end
    end

    // Request flags: clearing the lowest set bit leaves something only if
    // at least two bits were set.
    always_comb begin
        any_c   = |I;
        multi_c = |(I & (I - IN_W'(1)));
    end

    // Next-state values; a disabled encoder reports no request at index 0.
    always_comb begin
        y_d = '0;
        v_d = 1'b0;
        m_d = 1'b0;
        if (E) begin
            y_d = idx_c;
            v_d = any_c;
            m_d = multi_c;
        end
    end

    // Output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
            v_q <= 1'b0;
            m_q <= 1'b0;
        end else begin
            y_q <= y_d;
            v_q <= v_d;
            m_q <= m_d;
        end
    end

    assign Y = y_q;
    assign V = v_q;
    assign M = m_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// tb_encoder_8to3: self-checking bench for the registered 8-to-3 priority encoder.
module tb_encoder_8to3;

    typedef struct {
        logic       e;
        logic [7:0] i;
        logic [2:0] y;
        logic       v;
        logic       m;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       E;
    logic [7:0] I;
    logic [2:0] Y;
    logic       V;
    logic       M;

    int n_cmp;
    int n_err;

    encoder_8to3 dut (
        .clk (clk),
        .rst (rst),
        .E   (E),
        .I   (I),
        .Y   (Y),
        .V   (V),
        .M   (M)
    );

    // 10 time-unit clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] ey,
                         input logic ev, input logic em);
        n_cmp++;
        if (Y !== ey || V !== ev || M !== em) begin
            n_err++;
            $display("FAIL %s: got Y=%0d V=%0b M=%0b, required Y=%0d V=%0b M=%0b",
                     name, Y, V, M, ey, ev, em);
        end
    endtask

    // Reference: count set bits and take floor(log2(I)) arithmetically.
    function automatic void ref_model(input logic e, input logic [7:0] i,
                                      output logic [2:0] y, output logic v,
                                      output logic m);
        int x;
        int cnt;
        int hi;
        x   = int'(i);
        cnt = 0;
        for (int b = 0; b < 8; b++) cnt += (x >> b) & 1;
        hi = 0;
        while (x > 1) begin
            x = x / 2;
            hi++;
        end
        if (!e) begin
            y = 3'd0;
            v = 1'b0;
            m = 1'b0;
        end else begin
            y = 3'(hi);
            v = (cnt >= 1);
            m = (cnt >= 2);
        end
    endfunction

    initial begin
        vec_t       tbl[$];
        logic [2:0] ey;
        logic       ev;
        logic       em;
        logic       have;
        logic       re;
        logic [7:0] ri;

        n_cmp = 0;
        n_err = 0;

        tbl.push_back('{1'b0, 8'h80, 3'd0, 1'b0, 1'b0, "dis_80"});
        tbl.push_back('{1'b0, 8'h01, 3'd0, 1'b0, 1'b0, "dis_01"});
        tbl.push_back('{1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "oh_01"});
        tbl.push_back('{1'b1, 8'h02, 3'd1, 1'b1, 1'b0, "oh_02"});
        tbl.push_back('{1'b1, 8'h04, 3'd2, 1'b1, 1'b0, "oh_04"});
        tbl.push_back('{1'b1, 8'h08, 3'd3, 1'b1, 1'b0, "oh_08"});
        tbl.push_back('{1'b1, 8'h10, 3'd4, 1'b1, 1'b0, "oh_10"});
        tbl.push_back('{1'b1, 8'h20, 3'd5, 1'b1, 1'b0, "oh_20"});
        tbl.push_back('{1'b1, 8'h40, 3'd6, 1'b1, 1'b0, "oh_40"});
        tbl.push_back('{1'b1, 8'h80, 3'd7, 1'b1, 1'b0, "oh_80"});
        tbl.push_back('{1'b1, 8'h81, 3'd7, 1'b1, 1'b1, "pri_81"});
        tbl.push_back('{1'b1, 8'h16, 3'd4, 1'b1, 1'b1, "pri_16"});
        tbl.push_back('{1'b1, 8'h03, 3'd1, 1'b1, 1'b1, "pri_03"});
        tbl.push_back('{1'b1, 8'hFF, 3'd7, 1'b1, 1'b1, "pri_FF"});
        tbl.push_back('{1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "empty_00"});
        tbl.push_back('{1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "after_empty_01"});
        tbl.push_back('{1'b0, 8'hFF, 3'd0, 1'b0, 1'b0, "dis_FF"});

        // Reset held with active inputs: outputs stay cleared across edges.
        rst = 1'b1;
        E   = 1'b1;
        I   = 8'hFF;
        #1;
        check("rst_initial", 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_held", 3'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        E   = 1'b0;
        I   = 8'h00;

        // Table vectors: drive on falling edge, check one rising edge later.
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            E = tbl[k].e;
            I = tbl[k].i;
            @(negedge clk);
            check(tbl[k].name, tbl[k].y, tbl[k].v, tbl[k].m);
        end

        // Enable toggle with I held: output lags E by one cycle.
        @(negedge clk);
        I = 8'h40;
        E = 1'b1;
        @(negedge clk);
        check("en_tog_1", 3'd6, 1'b1, 1'b0);
        E = 1'b0;
        @(negedge clk);
        check("en_tog_0", 3'd0, 1'b0, 1'b0);
        E = 1'b1;
        @(negedge clk);
        check("en_tog_1b", 3'd6, 1'b1, 1'b0);

        // Input change between edges must not reach the outputs.
        @(negedge clk);
        E = 1'b1;
        I = 8'h80;
        @(posedge clk);
        #2;
        I = 8'h01;
        E = 1'b0;
        #2;
        check("no_comb_path", 3'd7, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle after a valid encode.
        @(negedge clk);
        E = 1'b1;
        I = 8'h20;
        @(posedge clk);
        #2;
        check("pre_async_rst", 3'd5, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_now", 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("async_rst_edge", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release", 3'd5, 1'b1, 1'b0);

        // Randomized pipelined stream against the reference model.
        have = 1'b0;
        ey   = '0;
        ev   = 1'b0;
        em   = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (have) check("rand", ey, ev, em);
            re = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       ri = 8'(1 << $urandom_range(0, 7));
                1:       ri = 8'h00;
                default: ri = 8'($urandom);
            endcase
            E = re;
            I = ri;
            ref_model(re, ri, ey, ev, em);
            have = 1'b1;
        end
        @(negedge clk);
        check("rand_last", ey, ev, em);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
